// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - detector state encoding and transition helpers
package seq_detect_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S1     = 3'd1,
        S11    = 3'd2,
        S10    = 3'd3,
        HIT110 = 3'd4,
        HIT101 = 3'd5
    } det_state_t;

    // Each state names the longest suffix still useful for a 110/101 match.
    function automatic det_state_t det_next(input det_state_t s, input logic b);
        det_state_t n;
        case (s)
            IDLE:    n = b ? S1     : IDLE;
            S1:      n = b ? S11    : S10;
            S11:     n = b ? S11    : HIT110;
            S10:     n = b ? HIT101 : IDLE;
            HIT110:  n = b ? HIT101 : IDLE;
            HIT101:  n = b ? S11    : S10;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    function automatic logic det_is_hit(input det_state_t s);
        return (s == HIT110) || (s == HIT101);
    endfunction

endpackage

// File: rtl/seq_detect_scheduler_if.sv
// rtl/seq_detect_scheduler_if.sv - channel, detect-report and counter-read signals
interface seq_detect_scheduler_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]  ch_valid;
    logic [N_CH-1:0]  ch_bit;
    logic [N_CH-1:0]  ch_ready;
    logic [N_CH-1:0]  ch_clear;
    logic [N_CH-1:0]  ch_hit;
    logic             det_valid;
    logic [CH_W-1:0]  det_ch;
    logic             det_hit;
    logic             det_kind;
    logic [CH_W-1:0]  rd_ch;
    logic [CNT_W-1:0] rd_cnt;

    modport master (
        output ch_valid, ch_bit, ch_clear, rd_ch,
        input  ch_ready, ch_hit, det_valid, det_ch, det_hit, det_kind, rd_cnt
    );

    modport slave (
        input  ch_valid, ch_bit, ch_clear, rd_ch,
        output ch_ready, ch_hit, det_valid, det_ch, det_hit, det_kind, rd_cnt
    );
endinterface

// File: rtl/seq_detect_core.sv
// rtl/seq_detect_core.sv - shared combinational 110/101 transition and hit decode
module seq_detect_core
    import seq_detect_pkg::*;
(
    input  det_state_t state,
    input  logic       bit_in,
    output det_state_t next_state,
    output logic       hit,
    output logic       kind
);
    assign next_state = det_next(state, bit_in);
    assign hit        = det_is_hit(next_state);
    assign kind       = (next_state == HIT101);
endmodule

// File: rtl/seq_detect_scheduler.sv
// rtl/seq_detect_scheduler.sv - round-robin time sharing of one detector across N_CH streams
module seq_detect_scheduler
    import seq_detect_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detect_scheduler_if.slave bus
);
    localparam int CH_W = $clog2(N_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    det_state_t       state_q [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CH_W-1:0]  rr_ptr;

    logic [N_CH-1:0]  eligible;
    logic             grant_vld;
    logic [CH_W-1:0]  grant_ch;
    int               idx;

    det_state_t       cur_state;
    det_state_t       nxt_state;
    logic             cur_bit;
    logic             nxt_hit;
    logic             nxt_kind;

    // A channel being cleared forfeits its slot this cycle.
    assign eligible = bus.ch_valid & ~bus.ch_clear;

    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        idx       = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = (int'(rr_ptr) + k) % N_CH;
            if (!grant_vld && eligible[idx]) begin
                grant_vld = 1'b1;
                grant_ch  = CH_W'(idx);
            end
        end
    end

    always_comb begin
        bus.ch_ready = '0;
        bus.ch_hit   = '0;
        for (int i = 0; i < N_CH; i++) begin
            bus.ch_ready[i] = grant_vld && (grant_ch == CH_W'(i));
            bus.ch_hit[i]   = det_is_hit(state_q[i]);
        end
    end

    always_comb begin
        bus.rd_cnt = '0;
        if (int'(bus.rd_ch) < N_CH)
            bus.rd_cnt = cnt_q[bus.rd_ch];
    end

    assign cur_state = state_q[grant_ch];
    assign cur_bit   = bus.ch_bit[grant_ch];

    seq_detect_core u_core (
        .state      (cur_state),
        .bit_in     (cur_bit),
        .next_state (nxt_state),
        .hit        (nxt_hit),
        .kind       (nxt_kind)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            rr_ptr        <= '0;
            bus.det_valid <= 1'b0;
            bus.det_ch    <= '0;
            bus.det_hit   <= 1'b0;
            bus.det_kind  <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.ch_clear[i]) begin
                    state_q[i] <= IDLE;
                    cnt_q[i]   <= '0;
                end else if (grant_vld && (grant_ch == CH_W'(i))) begin
                    state_q[i] <= nxt_state;
                    if (nxt_hit && (cnt_q[i] != CNT_MAX))
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
            if (grant_vld)
                rr_ptr <= (int'(grant_ch) == N_CH - 1) ? '0 : grant_ch + CH_W'(1);
            bus.det_valid <= grant_vld;
            bus.det_ch    <= grant_vld ? grant_ch : '0;
            bus.det_hit   <= grant_vld & nxt_hit;
            bus.det_kind  <= grant_vld & nxt_kind;
        end
    end
endmodule
